// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: ALU op codes, forward selects,
// FSM state encoding and the combinational ALU/forwarding helpers.
package ex_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctl_t;

    // Select code 11 is not a valid forward and falls back to the RF value.
    function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                            input logic [31:0] rf,
                                            input logic [31:0] mem,
                                            input logic [31:0] wb);
        logic [31:0] v;
        case (sel)
            FWD_MEM: v = mem;
            FWD_WB:  v = wb;
            default: v = rf;
        endcase
        return v;
    endfunction

    // Single-cycle ALU; MUL and the unused codes yield 0 here.
    function automatic logic [31:0] alu_op(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] v;
        case (op)
            ALU_AND: v = a & b;
            ALU_OR:  v = a | b;
            ALU_ADD: v = a + b;
            ALU_SUB: v = a - b;
            ALU_SLT: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, 32 steps,
// low 32 bits of the product. Only used when EX_MUL_EN is defined.
import ex_pkg::*;

module seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [31:0] acc_reg;
    logic [4:0]  count_reg;
    logic        busy_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (abort) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= {mcand_reg[30:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[31:1]};
            count_reg  <= count_reg + 5'd1;
            if (count_reg == 5'd31) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // done flags the final step; the product register is complete after that edge.
    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == 5'd31);
    assign product = acc_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Define EX_MUL_EN to build in the 32-cycle iterative multiplier and Stall.
import ex_pkg::*;

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALUControl,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic [31:0] ReadDataRF0,
    input  logic [31:0] ReadDataRF1,
    input  logic [31:0] SignExtended,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] ALUResultMEM,
    input  logic [31:0] WriteDataWB,
    input  logic        Flush,
    output logic        Stall,
    output logic [31:0] ALUResultOut,
    output logic [31:0] WriteDataOut,
    output logic [4:0]  WriteRegOut,
    output logic        ZeroOut,
    output logic        RegWriteOut,
    output logic        MemReadOut,
    output logic        MemWriteOut,
    output logic        MemToRegOut
);

    logic [31:0] op_a;
    logic [31:0] b_fwd;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [4:0]  wreg_in;
    ctl_t        ctl_in;

    logic [31:0] result_reg, result_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [4:0]  wreg_reg, wreg_next;
    logic        zero_reg, zero_next;
    ctl_t        ctl_reg, ctl_next;

    assign op_a       = fwd_sel(ForwardA, ReadDataRF0, ALUResultMEM, WriteDataWB);
    assign b_fwd      = fwd_sel(ForwardB, ReadDataRF1, ALUResultMEM, WriteDataWB);
    assign op_b       = ALUSrc ? SignExtended : b_fwd;
    assign alu_result = alu_op(ALUControl, op_a, op_b);
    assign wreg_in    = RegDst ? Rd : Rt;
    assign ctl_in     = '{reg_write: RegWrite, mem_read: MemRead,
                          mem_write: MemWrite, mem_to_reg: MemToReg};

`ifdef EX_MUL_EN
    logic [1:0]  state_reg, state_next;
    ctl_t        held_ctl_reg;
    logic [4:0]  held_wreg_reg;
    logic [31:0] held_wdata_reg;
    logic        is_mul;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;

    assign is_mul    = (ALUControl == ALU_MUL);
    assign mul_start = (state_reg == S_IDLE) && is_mul && !Flush;
    assign Stall     = rst && !Flush && (((state_reg == S_IDLE) && is_mul) || mul_busy);

    seq_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (Flush),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_next = state_reg;
        if (Flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (mul_start) state_next = S_BUSY;
                S_BUSY:  if (mul_done)  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Destination and store data are latched with the operands: ID/EX may be
    // released the instant the product is written back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            held_ctl_reg   <= '0;
            held_wreg_reg  <= '0;
            held_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (mul_start) begin
                held_ctl_reg   <= ctl_in;
                held_wreg_reg  <= wreg_in;
                held_wdata_reg <= b_fwd;
            end
        end
    end

    always_comb begin
        result_next = result_reg;
        wdata_next  = wdata_reg;
        wreg_next   = wreg_reg;
        zero_next   = zero_reg;
        ctl_next    = '0;
        if (!Flush) begin
            case (state_reg)
                S_IDLE: begin
                    if (!is_mul) begin
                        result_next = alu_result;
                        wdata_next  = b_fwd;
                        wreg_next   = wreg_in;
                        zero_next   = (alu_result == 32'd0);
                        ctl_next    = ctl_in;
                    end
                end
                S_DONE: begin
                    result_next = mul_product;
                    wdata_next  = held_wdata_reg;
                    wreg_next   = held_wreg_reg;
                    zero_next   = (mul_product == 32'd0);
                    ctl_next    = held_ctl_reg;
                end
                default: ;
            endcase
        end
    end
`else
    assign Stall = 1'b0;

    always_comb begin
        result_next = result_reg;
        wdata_next  = wdata_reg;
        wreg_next   = wreg_reg;
        zero_next   = zero_reg;
        ctl_next    = '0;
        if (!Flush) begin
            result_next = alu_result;
            wdata_next  = b_fwd;
            wreg_next   = wreg_in;
            zero_next   = (alu_result == 32'd0);
            ctl_next    = ctl_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_reg <= '0;
            wdata_reg  <= '0;
            wreg_reg   <= '0;
            zero_reg   <= 1'b0;
            ctl_reg    <= '0;
        end else begin
            result_reg <= result_next;
            wdata_reg  <= wdata_next;
            wreg_reg   <= wreg_next;
            zero_reg   <= zero_next;
            ctl_reg    <= ctl_next;
        end
    end

    assign ALUResultOut = result_reg;
    assign WriteDataOut = wdata_reg;
    assign WriteRegOut  = wreg_reg;
    assign ZeroOut      = zero_reg;
    assign RegWriteOut  = ctl_reg.reg_write;
    assign MemReadOut   = ctl_reg.mem_read;
    assign MemWriteOut  = ctl_reg.mem_write;
    assign MemToRegOut  = ctl_reg.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ALU traffic
// against a behavioural model, and multiplier sequences when EX_MUL_EN is defined.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  ALUControl;
    logic        ALUSrc, RegDst;
    logic [31:0] ReadDataRF0, ReadDataRF1, SignExtended;
    logic [4:0]  Rt, Rd;
    logic        RegWrite, MemRead, MemWrite, MemToReg;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] ALUResultMEM, WriteDataWB;
    logic        Flush;
    logic        Stall;
    logic [31:0] ALUResultOut, WriteDataOut;
    logic [4:0]  WriteRegOut;
    logic        ZeroOut, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut;

    int compared   = 0;
    int mismatched = 0;

    // Model of what EX/MEM should hold (data is held across bubbles).
    logic [31:0] exp_res, exp_wd;
    logic [4:0]  exp_wr;
    logic        exp_zero;

    ex_stage dut (
        .clk(clk), .rst(rst), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .ReadDataRF0(ReadDataRF0), .ReadDataRF1(ReadDataRF1), .SignExtended(SignExtended),
        .Rt(Rt), .Rd(Rd), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ALUResultMEM(ALUResultMEM), .WriteDataWB(WriteDataWB), .Flush(Flush),
        .Stall(Stall), .ALUResultOut(ALUResultOut), .WriteDataOut(WriteDataOut),
        .WriteRegOut(WriteRegOut), .ZeroOut(ZeroOut), .RegWriteOut(RegWriteOut),
        .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut), .MemToRegOut(MemToRegOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        logic        alusrc, regdst;
        logic [31:0] rf0, rf1, sext, mem, wb;
        logic [4:0]  rt, rd;
        logic [3:0]  ctl;
        logic [31:0] er, ewd;
        logic [4:0]  ewr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(logic [2:0] op, logic [1:0] fa, logic [1:0] fb,
                                 logic alusrc, logic regdst, logic [31:0] rf0,
                                 logic [31:0] rf1, logic [31:0] sext, logic [31:0] mem,
                                 logic [31:0] wb, logic [4:0] rt, logic [4:0] rd,
                                 logic [3:0] ctl, logic [31:0] er, logic [31:0] ewd,
                                 logic [4:0] ewr);
        vec_t v;
        v.op = op; v.fa = fa; v.fb = fb; v.alusrc = alusrc; v.regdst = regdst;
        v.rf0 = rf0; v.rf1 = rf1; v.sext = sext; v.mem = mem; v.wb = wb;
        v.rt = rt; v.rd = rd; v.ctl = ctl; v.er = er; v.ewd = ewd; v.ewr = ewr;
        return v;
    endfunction

    // Reference model: operand choice and arithmetic straight from the op table.
    function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf,
                                         logic [31:0] mem, logic [31:0] wb);
        if (sel == 2'b10) return mem;
        if (sel == 2'b01) return wb;
        return rf;
    endfunction

    function automatic logic [31:0] model_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: return (sa < sb) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
            3'b011: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                         input logic alusrc, input logic regdst, input logic [31:0] rf0,
                         input logic [31:0] rf1, input logic [31:0] sext,
                         input logic [31:0] mem, input logic [31:0] wb,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ctl,
                         input logic flush);
        ALUControl = op; ForwardA = fa; ForwardB = fb; ALUSrc = alusrc; RegDst = regdst;
        ReadDataRF0 = rf0; ReadDataRF1 = rf1; SignExtended = sext;
        ALUResultMEM = mem; WriteDataWB = wb; Rt = rt; Rd = rd;
        {RegWrite, MemRead, MemWrite, MemToReg} = ctl;
        Flush = flush;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ectl);
        chk({tag, ".res"},  ALUResultOut, exp_res);
        chk({tag, ".wd"},   WriteDataOut, exp_wd);
        chk({tag, ".wr"},   {27'd0, WriteRegOut}, {27'd0, exp_wr});
        chk({tag, ".zero"}, {31'd0, ZeroOut}, {31'd0, exp_zero});
        chk({tag, ".ctl"},  {28'd0, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut},
            {28'd0, ectl});
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [3:0] ctl);
        int n;
        drive(3'b011, 2'b00, 2'b00, 1'b0, 1'b1, a, b, 32'd0, 32'd0, 32'd0, 5'd0, rd, ctl, 1'b0);
        #1;
        chk("mul.stall_start", {31'd0, Stall}, 32'd1);
        n = 0;
        while (Stall && n < 40) begin
            tick();
            n++;
            chk("mul.bubble", {28'd0, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut}, 32'd0);
        end
        chk("mul.stall_cycles", n, 33);
        tick();
        exp_res = a * b; exp_wd = b; exp_wr = rd; exp_zero = (exp_res == 32'd0);
        check_out("mul.result", ctl);
        $display("mul %h * %h -> %h after %0d stall cycles", a, b, ALUResultOut, n);
    endtask
`endif

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, bf;
        logic [3:0]  ctl;
        logic [4:0]  rt, rd;
        logic [1:0]  fa, fb;
        logic        src, dst, fl;
        logic [31:0] rf0, rf1, sx, mm, wb;

        // Reset, with a MUL presented so Stall must be masked by reset.
        rst = 1'b0;
        drive(3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0,
              5'd1, 5'd2, 4'b1111, 1'b0);
        repeat (2) tick();
        exp_res = 0; exp_wd = 0; exp_wr = 0; exp_zero = 0;
        check_out("reset", 4'b0000);
        chk("reset.stall", {31'd0, Stall}, 32'd0);
        drive(3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
              5'd0, 5'd0, 4'b0000, 1'b0);
        rst = 1'b1;

        vq.push_back(mkv(3'b010, 2'b10, 2'b00, 0, 0, 32'hDEAD_BEEF, 32'd5, 0, 32'h10, 0, 5'd3, 5'd4, 4'b1000, 32'h15, 32'd5, 5'd3));
        vq.push_back(mkv(3'b111, 2'b00, 2'b00, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 5'd2, 5'd7, 4'b1000, 32'd1, 32'd1, 5'd7));
        vq.push_back(mkv(3'b110, 2'b00, 2'b00, 0, 1, 32'd7, 32'd7, 0, 0, 0, 5'd2, 5'd8, 4'b1000, 32'd0, 32'd7, 5'd8));
        vq.push_back(mkv(3'b000, 2'b00, 2'b01, 0, 0, 32'hF0F0_FF00, 32'd0, 0, 0, 32'h0FF0_F0F0, 5'd9, 5'd1, 4'b1000, 32'h00F0_F000, 32'h0FF0_F0F0, 5'd9));
        vq.push_back(mkv(3'b001, 2'b01, 2'b00, 1, 0, 32'd0, 32'hAAAA, 32'hFF, 0, 32'h1200_0000, 5'd10, 5'd1, 4'b0010, 32'h1200_00FF, 32'hAAAA, 5'd10));
        vq.push_back(mkv(3'b010, 2'b00, 2'b00, 1, 0, 32'hFFFF_FFFF, 32'h55, 32'd1, 0, 0, 5'd11, 5'd1, 4'b1101, 32'd0, 32'h55, 5'd11));
        vq.push_back(mkv(3'b100, 2'b00, 2'b00, 0, 0, 32'd3, 32'd4, 0, 0, 0, 5'd12, 5'd1, 4'b1000, 32'd0, 32'd4, 5'd12));
        vq.push_back(mkv(3'b101, 2'b00, 2'b00, 0, 0, 32'd3, 32'd4, 0, 0, 0, 5'd13, 5'd1, 4'b1000, 32'd0, 32'd4, 5'd13));
        vq.push_back(mkv(3'b010, 2'b11, 2'b11, 0, 0, 32'd5, 32'd6, 0, 32'd100, 32'd200, 5'd14, 5'd1, 4'b1000, 32'd11, 32'd6, 5'd14));
        vq.push_back(mkv(3'b110, 2'b00, 2'b00, 0, 0, 32'd3, 32'd5, 0, 0, 0, 5'd15, 5'd1, 4'b0100, 32'hFFFF_FFFE, 32'd5, 5'd15));
        vq.push_back(mkv(3'b111, 2'b00, 2'b10, 0, 0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 0, 5'd16, 5'd1, 4'b1000, 32'd0, 32'hFFFF_FFFF, 5'd16));
        vq.push_back(mkv(3'b111, 2'b00, 2'b00, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 5'd17, 5'd1, 4'b1000, 32'd1, 32'h7FFF_FFFF, 5'd17));
`ifndef EX_MUL_EN
        vq.push_back(mkv(3'b011, 2'b00, 2'b00, 0, 0, 32'd6, 32'd7, 0, 0, 0, 5'd18, 5'd1, 4'b1000, 32'd0, 32'd7, 5'd18));
`endif

        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].fa, vq[i].fb, vq[i].alusrc, vq[i].regdst, vq[i].rf0,
                  vq[i].rf1, vq[i].sext, vq[i].mem, vq[i].wb, vq[i].rt, vq[i].rd,
                  vq[i].ctl, 1'b0);
            #1;
            chk("vec.stall", {31'd0, Stall}, 32'd0);
            tick();
            exp_res = vq[i].er; exp_wd = vq[i].ewd; exp_wr = vq[i].ewr;
            exp_zero = (vq[i].er == 32'd0);
            check_out($sformatf("vec%0d", i), vq[i].ctl);
            $display("vec %0d op=%b res=%h wr=%0d", i, vq[i].op, ALUResultOut, WriteRegOut);
        end

        // Flush of a plain op: bubble, data held.
        drive(3'b010, 2'b00, 2'b00, 0, 0, 32'd1, 32'd2, 0, 0, 0, 5'd20, 5'd21, 4'b1111, 1'b1);
        tick();
        check_out("flush", 4'b0000);
        $display("flush bubble ctl=%b%b%b%b", RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut);

        // Randomized traffic against the behavioural model.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 7))
                0: op = 3'b000; 1: op = 3'b001; 2: op = 3'b010; 3: op = 3'b110;
                4: op = 3'b111; 5: op = 3'b100; 6: op = 3'b101;
`ifdef EX_MUL_EN
                default: op = 3'b010;
`else
                default: op = 3'b011;
`endif
            endcase
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            src = 1'($urandom_range(0, 1)); dst = 1'($urandom_range(0, 1));
            rf0 = $urandom; rf1 = ($urandom_range(0, 3) == 0) ? rf0 : $urandom;
            sx = $urandom; mm = $urandom; wb = $urandom;
            rt = 5'($urandom); rd = 5'($urandom); ctl = 4'($urandom);
            fl = ($urandom_range(0, 9) == 0);
            drive(op, fa, fb, src, dst, rf0, rf1, sx, mm, wb, rt, rd, ctl, fl);
            #1;
            chk("rand.stall", {31'd0, Stall}, 32'd0);
            tick();
            if (!fl) begin
                a  = pick(fa, rf0, mm, wb);
                bf = pick(fb, rf1, mm, wb);
                b  = src ? sx : bf;
                exp_res = model_alu(op, a, b); exp_wd = bf; exp_wr = dst ? rd : rt;
                exp_zero = (exp_res == 32'd0);
            end
            check_out("rand", fl ? 4'b0000 : ctl);
            $display("rand %0d op=%b flush=%0d res=%h", t, op, fl, ALUResultOut);
        end

`ifdef EX_MUL_EN
        run_mul(32'h0001_0003, 32'h0000_0005, 5'd9, 4'b1000);
        for (int k = 0; k < 3; k++) run_mul($urandom, $urandom, 5'($urandom), 4'($urandom));

        // Flush at BUSY count 10.
        drive(3'b011, 2'b00, 2'b00, 0, 1, 32'd3, 32'd4, 0, 0, 0, 5'd0, 5'd5, 4'b1000, 1'b0);
        repeat (11) tick();
        chk("mflush.stall_before", {31'd0, Stall}, 32'd1);
        Flush = 1'b1;
        #1;
        chk("mflush.stall_drop", {31'd0, Stall}, 32'd0);
        tick();
        check_out("mflush.bubble", 4'b0000);
        drive(3'b010, 2'b00, 2'b00, 0, 1, 32'd10, 32'd20, 0, 0, 0, 5'd0, 5'd6, 4'b1000, 1'b0);
        #1;
        chk("mflush.idle", {31'd0, Stall}, 32'd0);
        tick();
        exp_res = 32'd30; exp_wd = 32'd20; exp_wr = 5'd6; exp_zero = 1'b0;
        check_out("mflush.next", 4'b1000);
        $display("mul flushed at count 10, next res=%h", ALUResultOut);

        // Flush in IDLE with MUL present never starts the multiplier.
        drive(3'b011, 2'b00, 2'b00, 0, 1, 32'd3, 32'd4, 0, 0, 0, 5'd0, 5'd5, 4'b1000, 1'b1);
        #1;
        chk("iflush.stall", {31'd0, Stall}, 32'd0);
        tick();
        check_out("iflush.bubble", 4'b0000);
        drive(3'b000, 2'b00, 2'b00, 0, 0, 32'hFF, 32'h0F, 0, 0, 0, 5'd7, 5'd0, 4'b1000, 1'b0);
        #1;
        chk("iflush.idle", {31'd0, Stall}, 32'd0);
        tick();
        exp_res = 32'h0F; exp_wd = 32'h0F; exp_wr = 5'd7; exp_zero = 1'b0;
        check_out("iflush.next", 4'b1000);
        $display("idle flush of mul, next res=%h", ALUResultOut);

        // Reset at BUSY count 20.
        drive(3'b011, 2'b00, 2'b00, 0, 1, 32'd9, 32'd9, 0, 0, 0, 5'd0, 5'd5, 4'b1111, 1'b0);
        repeat (21) tick();
        rst = 1'b0;
        #1;
        exp_res = 0; exp_wd = 0; exp_wr = 0; exp_zero = 0;
        check_out("mreset", 4'b0000);
        chk("mreset.stall", {31'd0, Stall}, 32'd0);
        drive(3'b010, 2'b00, 2'b00, 0, 0, 32'd2, 32'd3, 0, 0, 0, 5'd4, 5'd0, 4'b1000, 1'b0);
        #3;
        rst = 1'b1;
        tick();
        exp_res = 32'd5; exp_wd = 32'd3; exp_wr = 5'd4; exp_zero = 1'b0;
        check_out("mreset.add", 4'b1000);
        $display("reset mid-mul, then add res=%h", ALUResultOut);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
